// File: rtl/fifo_burst_pkg.sv
// Shared types and helpers for the FIFO burst-drain blocks.
package fifo_burst_pkg;

  // Drain controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Beat width used by the default build; per-instance widths go through the function below
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned BYTES_PER_BEAT     = DEFAULT_DATA_WIDTH / 8;

  // Burst length register width: holds 1..256 beats
  localparam int unsigned LEN_WIDTH = 9;

  // Byte distance covered by a burst of len beats of data_width bits each
  function automatic logic [63:0] burst_addr_incr(input logic [LEN_WIDTH-1:0] len,
                                                  input int unsigned data_width);
    return 64'(len) * 64'(data_width / 8);
  endfunction

endpackage

// File: rtl/fifo_burst_timeout_cnt.sv
// Saturating idle counter with synchronous clear, increment enable and a
// terminal flag that stays high once the counter parks on TERMINAL.
module fifo_burst_timeout_cnt #(
  parameter int unsigned TERMINAL = 63,
  parameter int unsigned WIDTH    = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic term_o
);

  logic [WIDTH-1:0] cnt_reg;

  // Count up while enabled, stop at TERMINAL, clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr_i) begin
      cnt_reg <= '0;
    end else if (inc_i && (cnt_reg != WIDTH'(TERMINAL))) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign term_o = (cnt_reg == WIDTH'(TERMINAL));

endmodule

// File: rtl/fifo_burst_drain.sv
// Read-side consumer of the async FIFO: turns the occupancy count into
// full-length or timeout-triggered partial bursts (command, then data beats).
module fifo_burst_drain
  import fifo_burst_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 11,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_enable_i,
  input  logic [ADDR_WIDTH-1:0] cfg_base_i,
  input  logic                  cfg_load_i,
  input  logic [CNT_WIDTH-1:0]  fifo_cnt_i,
  input  logic                  fifo_rvalid_i,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                  fifo_rready_o,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic [ADDR_WIDTH-1:0] cmd_addr_o,
  output logic [7:0]            cmd_len_o,
  output logic                  d_valid_o,
  input  logic                  d_ready_i,
  output logic [DATA_WIDTH-1:0] d_data_o,
  output logic                  d_last_o,
  output logic                  busy_o
);

  localparam int unsigned TO_WIDTH = $clog2(TIMEOUT) + 1;

  state_t                 state_reg;
  logic [ADDR_WIDTH-1:0]  addr_reg;
  logic [LEN_WIDTH-1:0]   len_reg;
  logic [7:0]             beat_reg;

  logic in_idle;
  logic in_cmd;
  logic in_data;
  logic cnt_zero;
  logic cnt_full;
  logic to_term;
  logic to_inc;
  logic to_clr;
  logic go_full;
  logic go_partial;
  logic beat_fire;
  logic last_beat;

  assign in_idle = (state_reg == ST_IDLE);
  assign in_cmd  = (state_reg == ST_CMD);
  assign in_data = (state_reg == ST_DATA);

  assign cnt_zero = (fifo_cnt_i == '0);
  assign cnt_full = (fifo_cnt_i >= CNT_WIDTH'(MAX_BURST));

  // A full burst wins over an expiring timeout in the same cycle
  assign go_full    = in_idle && cfg_enable_i && cnt_full;
  assign go_partial = in_idle && cfg_enable_i && !cnt_zero && !cnt_full && to_term;

  // Only a partial, nonzero occupancy ages the timeout; anything else restarts it
  assign to_inc = in_idle && cfg_enable_i && !cnt_zero && !cnt_full;
  assign to_clr = !in_idle || !cfg_enable_i || cnt_zero || go_full || go_partial;

  fifo_burst_timeout_cnt #(
    .TERMINAL (TIMEOUT - 1),
    .WIDTH    (TO_WIDTH)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (to_clr),
    .inc_i  (to_inc),
    .term_o (to_term)
  );

  assign beat_fire = in_data && fifo_rvalid_i && d_ready_i;
  assign last_beat = (beat_reg == 8'(len_reg - 1'b1));

  // Burst sequencer: decide in IDLE, hold the command in CMD, count beats in DATA
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      addr_reg  <= cfg_base_i;
      len_reg   <= '0;
      beat_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cfg_load_i) begin
            addr_reg <= cfg_base_i;
          end
          if (go_full) begin
            len_reg   <= LEN_WIDTH'(MAX_BURST);
            state_reg <= ST_CMD;
          end else if (go_partial) begin
            // Count is below MAX_BURST here, so it always fits the length register
            len_reg   <= LEN_WIDTH'(fifo_cnt_i);
            state_reg <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (cmd_ready_i) begin
            addr_reg  <= addr_reg + ADDR_WIDTH'(burst_addr_incr(len_reg, DATA_WIDTH));
            beat_reg  <= '0;
            state_reg <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat_fire) begin
            if (last_beat) begin
              state_reg <= ST_IDLE;
            end else begin
              beat_reg <= beat_reg + 8'd1;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Command channel comes straight from held registers, so it is stable while waiting
  assign cmd_valid_o = in_cmd;
  assign cmd_addr_o  = addr_reg;
  assign cmd_len_o   = 8'(len_reg - 1'b1);

  // Data channel is a zero-latency pass-through of the FIFO head while in DATA
  assign d_valid_o     = in_data && fifo_rvalid_i;
  assign fifo_rready_o = in_data && d_ready_i;
  assign d_data_o      = fifo_rdata_i;
  assign d_last_o      = in_data && last_beat;

  assign busy_o = !in_idle;

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Self-checking bench for fifo_burst_drain: a cycle table for one full burst,
// hand-written multi-cycle corner cases, then random traffic against a
// transaction-level reference model of the drain rules.
module tb_fifo_burst_drain;

  localparam int DW = 32;
  localparam int CW = 11;
  localparam int MB = 16;
  localparam int TO = 64;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_enable_i = 1'b0;
  logic [AW-1:0] cfg_base_i = '0;
  logic          cfg_load_i = 1'b0;
  logic [CW-1:0] fifo_cnt_i = '0;
  logic          fifo_rvalid_i = 1'b0;
  logic [DW-1:0] fifo_rdata_i = '0;
  logic          fifo_rready_o;
  logic          cmd_valid_o;
  logic          cmd_ready_i = 1'b0;
  logic [AW-1:0] cmd_addr_o;
  logic [7:0]    cmd_len_o;
  logic          d_valid_o;
  logic          d_ready_i = 1'b0;
  logic [DW-1:0] d_data_o;
  logic          d_last_o;
  logic          busy_o;

  fifo_burst_drain #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW),
    .MAX_BURST  (MB),
    .TIMEOUT    (TO),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_enable_i  (cfg_enable_i),
    .cfg_base_i    (cfg_base_i),
    .cfg_load_i    (cfg_load_i),
    .fifo_cnt_i    (fifo_cnt_i),
    .fifo_rvalid_i (fifo_rvalid_i),
    .fifo_rdata_i  (fifo_rdata_i),
    .fifo_rready_o (fifo_rready_o),
    .cmd_valid_o   (cmd_valid_o),
    .cmd_ready_i   (cmd_ready_i),
    .cmd_addr_o    (cmd_addr_o),
    .cmd_len_o     (cmd_len_o),
    .d_valid_o     (d_valid_o),
    .d_ready_i     (d_ready_i),
    .d_data_o      (d_data_o),
    .d_last_o      (d_last_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Hold reset across two edges with the given base, release on a falling edge
  task automatic do_reset(input logic [AW-1:0] base);
    @(negedge clk);
    rst_n = 1'b0;
    cfg_base_i = base;
    cfg_enable_i = 1'b1;
    cfg_load_i = 1'b0;
    fifo_cnt_i = '0;
    fifo_rvalid_i = 1'b0;
    cmd_ready_i = 1'b0;
    d_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait for cmd_valid_o; periods counts the current clock period as 1, -1 on expiry
  task automatic wait_cmd(input int max_periods, output int periods);
    periods = -1;
    for (int p = 1; p <= max_periods; p++) begin
      #1;
      if (cmd_valid_o) begin
        periods = p;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Accept data beats from DATA state; optional d_ready toggling, enable drop, early stop
  task automatic drain(input bit toggle, input int disable_at, input int stop_after,
                       output int beats, output int last_beat);
    beats = 0;
    last_beat = 0;
    for (int c = 0; c < 200; c++) begin
      if (last_beat != 0) break;
      if (stop_after > 0 && beats == stop_after) break;
      d_ready_i = toggle ? ~c[0] : 1'b1;
      if (disable_at >= 0 && beats == disable_at) cfg_enable_i = 1'b0;
      #1;
      check("rready_mirrors_dready", {63'd0, fifo_rready_o}, {63'd0, d_ready_i});
      if (d_valid_o && d_ready_i) begin
        beats++;
        if (d_last_o) last_beat = beats;
      end
      @(negedge clk);
    end
  endtask

  typedef struct packed {
    logic          cmd_ready;
    logic          d_ready;
    logic          exp_busy;
    logic          exp_cmd_valid;
    logic          exp_d_valid;
    logic          exp_d_last;
    logic          exp_rready;
    logic [AW-1:0] exp_addr;
    logic [7:0]    exp_len;
  } vec_t;

  vec_t vecs[20];

  // Reference model state (random phase)
  int            m_phase;
  int            m_wait;
  int            m_len;
  int            m_beats;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] q[$];

  initial begin
    int p;
    int beats;
    int last;
    int ncmd;
    int regime;
    int push_pct;
    int cnt;
    bit pop;
    bit push;
    logic [AW-1:0] held_addr;
    logic [7:0]    held_len;
    logic [AW-1:0] rbase;
    logic [4:0]    exp_ctrl;

    // ---------------- reset state + full-burst cycle table ----------------
    do_reset(32'h1000);
    #1;
    check("reset_outputs", {59'd0, busy_o, cmd_valid_o, d_valid_o, d_last_o, fifo_rready_o}, 64'd0);
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      vecs[i] = '0;
      vecs[i].cmd_ready = 1'b1;
      vecs[i].d_ready = 1'b1;
    end
    vecs[1].exp_busy = 1'b1;
    vecs[1].exp_cmd_valid = 1'b1;
    vecs[1].exp_addr = 32'h1000;
    vecs[1].exp_len = 8'd15;
    for (int k = 0; k < 16; k++) begin
      vecs[2+k].exp_busy = 1'b1;
      vecs[2+k].exp_d_valid = 1'b1;
      vecs[2+k].exp_rready = 1'b1;
      vecs[2+k].exp_d_last = (k == 15);
    end
    vecs[19].exp_busy = 1'b1;
    vecs[19].exp_cmd_valid = 1'b1;
    vecs[19].exp_addr = 32'h1040;
    vecs[19].exp_len = 8'd15;

    fifo_cnt_i = CW'(16);
    fifo_rvalid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cmd_ready_i = vecs[i].cmd_ready;
      d_ready_i = vecs[i].d_ready;
      fifo_rdata_i = 32'hA500_0000 + 32'(i);
      #1;
      check($sformatf("vec%0d_ctrl", i),
            {59'd0, busy_o, cmd_valid_o, d_valid_o, d_last_o, fifo_rready_o},
            {59'd0, vecs[i].exp_busy, vecs[i].exp_cmd_valid, vecs[i].exp_d_valid,
             vecs[i].exp_d_last, vecs[i].exp_rready});
      if (vecs[i].exp_cmd_valid) begin
        check($sformatf("vec%0d_addr", i), 64'(cmd_addr_o), 64'(vecs[i].exp_addr));
        check($sformatf("vec%0d_len", i), 64'(cmd_len_o), 64'(vecs[i].exp_len));
      end
      if (vecs[i].exp_d_valid) begin
        check($sformatf("vec%0d_data", i), 64'(d_data_o), 64'(32'hA500_0000 + 32'(i)));
      end
      @(negedge clk);
    end
    $display("[TB] full burst table done");

    // ---------------- timeout partial ----------------
    do_reset(32'h2000);
    fifo_rvalid_i = 1'b1;
    d_ready_i = 1'b1;
    fifo_cnt_i = CW'(3);
    wait_cmd(200, p);
    check("timeout_latency", 64'(p), 64'd65);
    check("timeout_len", 64'(cmd_len_o), 64'd2);
    check("timeout_addr", 64'(cmd_addr_o), 64'h2000);
    cmd_ready_i = 1'b1;
    @(negedge clk);
    cmd_ready_i = 1'b0;
    drain(1'b0, -1, 0, beats, last);
    check("timeout_beats", 64'(beats), 64'd3);
    check("timeout_last", 64'(last), 64'd3);
    $display("[TB] timeout burst: latency=%0d beats=%0d", p, beats);

    // ---------------- full beats timeout in the same cycle ----------------
    do_reset(32'h1000);
    fifo_rvalid_i = 1'b1;
    d_ready_i = 1'b1;
    fifo_cnt_i = CW'(3);
    repeat (63) @(negedge clk);
    fifo_cnt_i = CW'(20);
    wait_cmd(5, p);
    check("priority_latency", 64'(p), 64'd2);
    check("priority_len", 64'(cmd_len_o), 64'd15);
    $display("[TB] priority burst: len=%0d", cmd_len_o);

    // ---------------- command and data backpressure ----------------
    do_reset(32'h1000);
    fifo_rvalid_i = 1'b1;
    d_ready_i = 1'b1;
    fifo_cnt_i = CW'(16);
    wait_cmd(10, p);
    check("bp_cmd_seen", 64'(p > 0), 64'd1);
    held_addr = cmd_addr_o;
    held_len = cmd_len_o;
    check("bp_addr", 64'(held_addr), 64'h1000);
    check("bp_len", 64'(held_len), 64'd15);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cfg_load_i = (i == 2);
      cfg_base_i = 32'h9000;
      #1;
      check("bp_hold", {23'd0, cmd_valid_o, cmd_addr_o, cmd_len_o, fifo_rready_o},
            {23'd0, 1'b1, held_addr, held_len, 1'b0});
    end
    @(negedge clk);
    cfg_load_i = 1'b0;
    cmd_ready_i = 1'b1;
    @(negedge clk);
    cmd_ready_i = 1'b0;
    fifo_cnt_i = '0;
    drain(1'b1, -1, 0, beats, last);
    check("bp_pops", 64'(beats), 64'd16);
    check("bp_last", 64'(last), 64'd16);
    d_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_no_extra_pop", {63'd0, fifo_rready_o}, 64'd0);
      @(negedge clk);
    end
    fifo_cnt_i = CW'(16);
    wait_cmd(10, p);
    check("bp_next_addr", 64'(cmd_addr_o), 64'h1040);
    $display("[TB] backpressure burst: pops=%0d", beats);

    // ---------------- reset mid-DATA ----------------
    do_reset(32'h1000);
    fifo_rvalid_i = 1'b1;
    d_ready_i = 1'b1;
    fifo_cnt_i = CW'(16);
    cmd_ready_i = 1'b1;
    wait_cmd(10, p);
    @(negedge clk);
    cmd_ready_i = 1'b0;
    drain(1'b0, -1, 7, beats, last);
    check("midreset_beats", 64'(beats), 64'd7);
    d_ready_i = 1'b1;
    #1;
    check("midreset_pre_dvalid", {63'd0, d_valid_o}, 64'd1);
    #2;
    rst_n = 1'b0;
    cfg_base_i = 32'h3000;
    #1;
    check("midreset_async_outputs",
          {59'd0, busy_o, cmd_valid_o, d_valid_o, d_last_o, fifo_rready_o}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cmd(10, p);
    check("midreset_addr", 64'(cmd_addr_o), 64'h3000);
    $display("[TB] reset mid-burst: restart addr=%08h", cmd_addr_o);

    // ---------------- load in IDLE, disable mid-burst ----------------
    do_reset(32'h1000);
    fifo_rvalid_i = 1'b1;
    d_ready_i = 1'b1;
    cfg_load_i = 1'b1;
    cfg_base_i = 32'h5000;
    @(negedge clk);
    cfg_load_i = 1'b0;
    cfg_base_i = 32'h1000;
    fifo_cnt_i = CW'(40);
    cmd_ready_i = 1'b1;
    wait_cmd(10, p);
    check("load_addr", 64'(cmd_addr_o), 64'h5000);
    check("disable_len", 64'(cmd_len_o), 64'd15);
    @(negedge clk);
    drain(1'b0, 4, 0, beats, last);
    check("disable_beats", 64'(beats), 64'd16);
    check("disable_last", 64'(last), 64'd16);
    ncmd = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (cmd_valid_o) ncmd++;
      @(negedge clk);
    end
    check("disable_no_cmd", 64'(ncmd), 64'd0);
    $display("[TB] disable mid-burst: beats=%0d later_cmds=%0d", beats, ncmd);

    // ---------------- random traffic vs reference model ----------------
    rbase = $urandom & 32'hFFFF_FFC0;
    do_reset(rbase);
    q.delete();
    m_phase = 0;
    m_wait = 0;
    m_addr = rbase;
    m_len = 0;
    m_beats = 0;
    for (int i = 0; i < 4000; i++) begin
      regime = (i / 500) % 4;
      push_pct = (regime == 0) ? 90 : (regime == 1) ? 30 : 3;
      cfg_enable_i = (regime == 3) ? (((i / 150) % 2) == 0) : 1'b1;
      cnt = q.size();
      fifo_cnt_i = CW'(cnt);
      fifo_rvalid_i = (cnt != 0) && (($urandom % 6) != 0);
      fifo_rdata_i = (cnt != 0) ? q[0] : '0;
      cmd_ready_i = ($urandom % 3) != 0;
      d_ready_i = ($urandom % 4) != 0;
      #1;
      exp_ctrl = {m_phase != 0, m_phase == 1, (m_phase == 2) && fifo_rvalid_i,
                  (m_phase == 2) && (m_beats == m_len - 1), (m_phase == 2) && d_ready_i};
      check("rand_ctrl", {59'd0, busy_o, cmd_valid_o, d_valid_o, d_last_o, fifo_rready_o},
            {59'd0, exp_ctrl});
      if (m_phase == 1) begin
        check("rand_cmd", {24'd0, cmd_addr_o, cmd_len_o}, {24'd0, m_addr, 8'(m_len - 1)});
      end
      if (m_phase == 2 && fifo_rvalid_i) begin
        check("rand_data", 64'(d_data_o), 64'(q[0]));
      end
      pop = (m_phase == 2) && fifo_rvalid_i && d_ready_i;
      // Model: full bursts first, then a partial once TIMEOUT idle partial cycles have passed
      case (m_phase)
        0: begin
          if (cfg_enable_i && cnt >= MB) begin
            m_phase = 1;
            m_len = MB;
            m_wait = 0;
          end else if (cfg_enable_i && cnt > 0 && m_wait == TO - 1) begin
            m_phase = 1;
            m_len = cnt;
            m_wait = 0;
          end else if (cfg_enable_i && cnt > 0) begin
            m_wait = (m_wait + 1 > TO - 1) ? TO - 1 : m_wait + 1;
          end else begin
            m_wait = 0;
          end
        end
        1: begin
          if (cmd_ready_i) begin
            $display("[TB] burst addr=%08h len=%0d", m_addr, m_len);
            m_addr = m_addr + AW'(m_len * (DW / 8));
            m_beats = 0;
            m_phase = 2;
          end
        end
        default: begin
          if (pop) begin
            if (m_beats == m_len - 1) m_phase = 0;
            else m_beats++;
          end
        end
      endcase
      push = (($urandom % 100) < push_pct) && (q.size() < 60);
      @(negedge clk);
      if (pop) void'(q.pop_front());
      if (push) q.push_back($urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute bound on run time
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_burst_drain.md
Name: fifo_burst_drain

Overview:
- Single-clock consumer on the read side of the gray-pointer async FIFO; runs in the FIFO's read clock domain.
- Watches the FIFO's read-side occupancy count and drains entries as fixed-length or timeout-triggered partial bursts.
- Each burst is one address/length command followed by a data beat stream with last, toward a memory-write master.
- Completes the FIFO path: the FIFO write side fills, this block empties in bursts.

Parameters:
- DATA_WIDTH, 32, FIFO word and data-beat width.
- CNT_WIDTH, 11, width of FIFO occupancy input (LOG_DEPTH+1).
- MAX_BURST, 16, beats per full burst; power of two, 1..256.
- TIMEOUT, 64, idle cycles with a partial (nonzero) occupancy before a partial burst is issued; >=1.
- ADDR_WIDTH, 32, command address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_enable_i  in  1  allow new bursts
- cfg_base_i  in  ADDR_WIDTH  start address, sampled while rst_n low or cfg_load_i high; must be aligned to MAX_BURST*DATA_WIDTH/8
- cfg_load_i  in  1  reload address counter from cfg_base_i (honoured in IDLE only)
- fifo_cnt_i  in  CNT_WIDTH  FIFO read-side occupancy (may under-report, never over-report)
- fifo_rvalid_i  in  1  FIFO head valid
- fifo_rdata_i  in  DATA_WIDTH  FIFO head data
- fifo_rready_o  out  1  pop FIFO head
- cmd_valid_o  out  1  burst command valid
- cmd_ready_i  in  1  command accepted
- cmd_addr_o  out  ADDR_WIDTH  burst start address
- cmd_len_o  out  8  beats minus one
- d_valid_o  out  1  data beat valid
- d_ready_i  in  1  data beat accepted
- d_data_o  out  DATA_WIDTH  beat data
- d_last_o  out  1  final beat of burst
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, addr counter = cfg_base_i, timeout counter 0, len register 0. All valid/ready/last outputs 0. busy_o 0.
- Reset mid-burst returns to IDLE immediately. Any partially sent burst is abandoned. The downstream side must also be reset.
- States: IDLE, CMD, DATA.
- IDLE, when cfg_enable_i=1:
  - fifo_cnt_i >= MAX_BURST: next state CMD, len = MAX_BURST.
  - Otherwise, if timeout counter == TIMEOUT-1 and fifo_cnt_i != 0: next state CMD, len = fifo_cnt_i.
  - A full burst takes priority over timeout in the same cycle.
- Timeout counter:
  - Increments in IDLE while enabled and 0 < fifo_cnt_i < MAX_BURST.
  - Clears to 0 on fifo_cnt_i == 0, on cfg_enable_i == 0, and on leaving IDLE.
  - Saturates; it never wraps.
- cfg_load_i in IDLE loads the address counter. It is ignored in CMD/DATA.
- CMD:
  - cmd_valid_o = 1, cmd_addr_o = addr counter, cmd_len_o = len-1; all held stable until cmd_ready_i.
  - On handshake: addr counter += len*DATA_WIDTH/8 (modulo 2^ADDR_WIDTH), beat counter = 0, next state DATA.
- DATA, pass-through with zero latency:
  - d_valid_o = fifo_rvalid_i.
  - fifo_rready_o = d_ready_i.
  - d_data_o = fifo_rdata_i.
  - d_last_o = (beat counter == len-1).
  - Each d_valid_o && d_ready_i increments the beat counter. The last beat returns to IDLE.
- Outside DATA: fifo_rready_o = 0, d_valid_o = 0, d_last_o = 0.
- Minimum one IDLE cycle between bursts, so command-to-command spacing is at least len+2 cycles.
- Committed len never exceeds fifo_cnt_i at decision time. Because the count never over-reports, all committed beats will arrive; gaps in fifo_rvalid_i only stall.
- cfg_enable_i deasserted during CMD/DATA: the current burst completes; no new burst starts.

Decomposition:
- Shared package fifo_burst_pkg:
  - state enum (IDLE, CMD, DATA);
  - localparam BYTES_PER_BEAT = DATA_WIDTH/8;
  - function computing the address increment.
- One natural sub-module: fifo_burst_timeout_cnt (saturating counter with clear/enable and terminal flag), reusable by other drain blocks.

Test Plan:
- Full burst: MAX_BURST=16, cfg_base_i=0x1000, fifo_cnt_i=16, rvalid high, ready high. Required: cmd addr 0x1000 len 15; 16 beats with d_last_o on beat 16; next command addr 0x1040.
- Timeout partial: fifo_cnt_i=3 held, TIMEOUT=64. Required: cmd_valid_o first asserts 65 cycles after count appears; len 2; 3 beats.
- Priority: timeout counter at 63 and fifo_cnt_i jumps 3->20 the same cycle. Required: full burst, len 15.
- Backpressure: cmd_ready_i low for 5 cycles, then d_ready_i toggling 1/0. Required: cmd fields stable while waiting; fifo_rready_o mirrors d_ready_i only in DATA; exactly 16 pops.
- Reset mid-DATA: rst_n low after beat 7. Required: outputs 0 asynchronously; after release IDLE, address counter = cfg_base_i.
- Disable mid-burst: cfg_enable_i=0 at beat 4 with fifo_cnt_i=40. Required: burst finishes 16 beats; no further cmd_valid_o.
